// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - prescaled multi-channel countdown timer bank with MMIO registers
// Optional channel-0 watchdog reset request: define TIMER_BANK_WATCHDOG_EN.
module timer_bank #(
    parameter int CHANNEL_COUNT  = 4,
    parameter int COUNTER_WIDTH  = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     resetActiveLow,
    input  logic                     ioWriteValid,
    input  logic [7:0]               ioWriteAddress,
    input  logic [31:0]              ioWriteData,
    input  logic                     ioReadValid,
    input  logic [7:0]               ioReadAddress,
    output logic [31:0]              ioReadData,
    output logic                     ioReadValidData,
    output logic [CHANNEL_COUNT-1:0] channelPending,
    output logic                     timerInterrupt,
    output logic                     systemResetRequest
);
    localparam logic [4:0] CHANNEL_LIMIT = 5'(CHANNEL_COUNT);

    logic [PRESCALE_WIDTH-1:0] prescaleReg;
    logic [PRESCALE_WIDTH-1:0] prescaleCount;
    logic                      tickArmed;
    logic                      tick;
    logic [CHANNEL_COUNT-1:0]  irqMask;
    logic [CHANNEL_COUNT-1:0]  pending;
    logic [CHANNEL_COUNT-1:0]  ctrlEnable;
    logic [CHANNEL_COUNT-1:0]  ctrlPeriodic;
    logic [COUNTER_WIDTH-1:0]  reloadReg [CHANNEL_COUNT];
    logic [COUNTER_WIDTH-1:0]  countReg  [CHANNEL_COUNT];

    logic [3:0]                wrChannel;
    logic [3:0]                rdChannel;
    logic                      wrChannelValid;
    logic                      rdChannelValid;
    logic                      wrPrescale;
    logic                      wrStatus;
    logic                      wrMask;
    logic [CHANNEL_COUNT-1:0]  wrCtrl;
    logic [CHANNEL_COUNT-1:0]  wrReload;
    logic [CHANNEL_COUNT-1:0]  expire;
    logic [CHANNEL_COUNT-1:0]  statusClear;
    logic [31:0]               readMux;
    logic                      unusedBits;

    assign unusedBits = ^ioWriteData;

    // Channel n lives at 0x10 + 0x10*n, so the upper nibble minus one is the index.
    assign wrChannel      = ioWriteAddress[7:4] - 4'd1;
    assign rdChannel      = ioReadAddress[7:4] - 4'd1;
    assign wrChannelValid = (ioWriteAddress[7:4] != 4'd0) && ({1'b0, wrChannel} < CHANNEL_LIMIT);
    assign rdChannelValid = (ioReadAddress[7:4] != 4'd0) && ({1'b0, rdChannel} < CHANNEL_LIMIT);

    assign wrPrescale  = ioWriteValid && (ioWriteAddress == 8'h00);
    assign wrStatus    = ioWriteValid && (ioWriteAddress == 8'h04);
    assign wrMask      = ioWriteValid && (ioWriteAddress == 8'h08);
    assign statusClear = wrStatus ? ioWriteData[CHANNEL_COUNT-1:0] : '0;

    assign tick           = tickArmed && (prescaleCount == prescaleReg);
    assign channelPending = pending;

    always_comb begin
        wrCtrl   = '0;
        wrReload = '0;
        expire   = '0;
        for (int n = 0; n < CHANNEL_COUNT; n++) begin
            wrCtrl[n]   = ioWriteValid && wrChannelValid && (wrChannel == 4'(n))
                          && (ioWriteAddress[3:0] == 4'h0);
            wrReload[n] = ioWriteValid && wrChannelValid && (wrChannel == 4'(n))
                          && (ioWriteAddress[3:0] == 4'h4);
            expire[n]   = tick && ctrlEnable[n] && !wrCtrl[n] && !wrReload[n]
                          && (countReg[n] == '0);
        end
    end

    // tickArmed keeps the first cycle after reset release tick-free.
    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            prescaleReg   <= '0;
            prescaleCount <= '0;
            tickArmed     <= 1'b0;
            irqMask       <= '0;
        end else begin
            tickArmed <= 1'b1;
            if (wrPrescale) begin
                prescaleReg   <= ioWriteData[PRESCALE_WIDTH-1:0];
                prescaleCount <= '0;
            end else if (tickArmed) begin
                prescaleCount <= tick ? '0 : prescaleCount + PRESCALE_WIDTH'(1);
            end
            if (wrMask) begin
                irqMask <= ioWriteData[CHANNEL_COUNT-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            ctrlEnable   <= '0;
            ctrlPeriodic <= '0;
            pending      <= '0;
            for (int n = 0; n < CHANNEL_COUNT; n++) begin
                reloadReg[n] <= '0;
                countReg[n]  <= '0;
            end
        end else begin
            pending <= (pending & ~statusClear) | expire;
            for (int n = 0; n < CHANNEL_COUNT; n++) begin
                if (wrCtrl[n]) begin
                    ctrlEnable[n]   <= ioWriteData[0];
                    ctrlPeriodic[n] <= ioWriteData[1];
                    if (ioWriteData[0] && !ctrlEnable[n]) begin
                        countReg[n] <= reloadReg[n];
                    end
                end else if (wrReload[n]) begin
                    reloadReg[n] <= ioWriteData[COUNTER_WIDTH-1:0];
                end else if (tick && ctrlEnable[n]) begin
                    if (countReg[n] != '0) begin
                        countReg[n] <= countReg[n] - COUNTER_WIDTH'(1);
                    end else if (ctrlPeriodic[n]) begin
                        countReg[n] <= reloadReg[n];
                    end else begin
                        ctrlEnable[n] <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef TIMER_BANK_WATCHDOG_EN
    // A second channel-0 expiry before software acknowledged the first means a hung system.
    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            systemResetRequest <= 1'b0;
        end else if (expire[0] && pending[0]) begin
            systemResetRequest <= 1'b1;
        end
    end
`else
    assign systemResetRequest = 1'b0;
`endif

    always_comb begin
        readMux = '0;
        case (ioReadAddress)
            8'h00:   readMux = 32'(prescaleReg);
            8'h04:   readMux = 32'(pending);
            8'h08:   readMux = 32'(irqMask);
            default: readMux = '0;
        endcase
        if (rdChannelValid) begin
            for (int n = 0; n < CHANNEL_COUNT; n++) begin
                if (rdChannel == 4'(n)) begin
                    case (ioReadAddress[3:0])
                        4'h0:    readMux = 32'({ctrlPeriodic[n], ctrlEnable[n]});
                        4'h4:    readMux = 32'(reloadReg[n]);
                        4'h8:    readMux = 32'(countReg[n]);
                        default: readMux = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            ioReadData      <= '0;
            ioReadValidData <= 1'b0;
            timerInterrupt  <= 1'b0;
        end else begin
            ioReadValidData <= ioReadValid;
            if (ioReadValid) begin
                ioReadData <= readMux;
            end
            timerInterrupt <= |(pending & irqMask);
        end
    end
endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - scenario tasks plus randomized one-shot timing against an arithmetic model
// Expectations for systemResetRequest follow TIMER_BANK_WATCHDOG_EN.
module tb_timer_bank;
    localparam int CH = 4;

`ifdef TIMER_BANK_WATCHDOG_EN
    localparam logic WATCHDOG = 1'b1;
`else
    localparam logic WATCHDOG = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          resetActiveLow = 1'b0;
    logic          ioWriteValid = 1'b0;
    logic [7:0]    ioWriteAddress = '0;
    logic [31:0]   ioWriteData = '0;
    logic          ioReadValid = 1'b0;
    logic [7:0]    ioReadAddress = '0;
    logic [31:0]   ioReadData;
    logic          ioReadValidData;
    logic [CH-1:0] channelPending;
    logic          timerInterrupt;
    logic          systemResetRequest;

    int checkCount = 0;
    int passCount  = 0;

    timer_bank #(.CHANNEL_COUNT(CH), .COUNTER_WIDTH(32), .PRESCALE_WIDTH(16)) dut (
        .clock(clock),
        .resetActiveLow(resetActiveLow),
        .ioWriteValid(ioWriteValid),
        .ioWriteAddress(ioWriteAddress),
        .ioWriteData(ioWriteData),
        .ioReadValid(ioReadValid),
        .ioReadAddress(ioReadAddress),
        .ioReadData(ioReadData),
        .ioReadValidData(ioReadValidData),
        .channelPending(channelPending),
        .timerInterrupt(timerInterrupt),
        .systemResetRequest(systemResetRequest)
    );

    always #5 clock = ~clock;

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic busWrite(input logic [7:0] addr, input logic [31:0] data);
        ioWriteValid   = 1'b1;
        ioWriteAddress = addr;
        ioWriteData    = data;
        step();
        ioWriteValid   = 1'b0;
    endtask

    task automatic busRead(input logic [7:0] addr, output logic [31:0] data, output logic valid);
        ioReadValid   = 1'b1;
        ioReadAddress = addr;
        step();
        ioReadValid   = 1'b0;
        data          = ioReadData;
        valid         = ioReadValidData;
    endtask

    task automatic doReset();
        resetActiveLow = 1'b0;
        step();
        resetActiveLow = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        v;
        #3;
        checkCount++;
        if (channelPending !== 4'b0) $display("FAIL reset_pending got %b want 0", channelPending); else passCount++;
        checkCount++;
        if (timerInterrupt !== 1'b0) $display("FAIL reset_irq got %b want 0", timerInterrupt); else passCount++;
        checkCount++;
        if (systemResetRequest !== 1'b0) $display("FAIL reset_sysreset got %b want 0", systemResetRequest); else passCount++;
        checkCount++;
        if (ioReadValidData !== 1'b0 || ioReadData !== 32'h0)
            $display("FAIL reset_read got %b/%h want 0/0", ioReadValidData, ioReadData); else passCount++;
        step();
        resetActiveLow = 1'b1;
        step();
        busRead(8'h08, rd, v);
        checkCount++;
        if (rd !== 32'h0 || v !== 1'b1) $display("FAIL reset_mask got %h/%b want 0/1", rd, v); else passCount++;
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        logic        v;
        doReset();
        busWrite(8'h08, 32'h1);
        busWrite(8'h00, 32'h0);
        busWrite(8'h14, 32'd3);
        busWrite(8'h10, 32'h1);
        repeat (3) step();
        checkCount++;
        if (channelPending !== 4'b0000) $display("FAIL oneshot_early got %b want 0000", channelPending); else passCount++;
        step();
        checkCount++;
        if (channelPending !== 4'b0001 || timerInterrupt !== 1'b0)
            $display("FAIL oneshot_expire got %b/%b want 0001/0", channelPending, timerInterrupt); else passCount++;
        step();
        checkCount++;
        if (timerInterrupt !== 1'b1) $display("FAIL oneshot_irq got %b want 1", timerInterrupt); else passCount++;
        busRead(8'h10, rd, v);
        checkCount++;
        if (rd !== 32'h0) $display("FAIL oneshot_ctrl got %h want 0", rd); else passCount++;
    endtask

    task automatic test_periodic();
        logic [31:0] rd;
        logic        v;
        doReset();
        busWrite(8'h00, 32'd2);
        busWrite(8'h24, 32'd1);
        busWrite(8'h20, 32'h3);
        repeat (3) step();
        checkCount++;
        if (channelPending !== 4'b0000) $display("FAIL periodic_early got %b want 0000", channelPending); else passCount++;
        step();
        checkCount++;
        if (channelPending !== 4'b0010) $display("FAIL periodic_first got %b want 0010", channelPending); else passCount++;
        busWrite(8'h04, 32'h2);
        checkCount++;
        if (channelPending !== 4'b0000) $display("FAIL periodic_w1c got %b want 0000", channelPending); else passCount++;
        busRead(8'h28, rd, v);
        checkCount++;
        if (rd !== 32'd1) $display("FAIL periodic_count got %0d want 1", rd); else passCount++;
        repeat (3) step();
        checkCount++;
        if (channelPending !== 4'b0000) $display("FAIL periodic_gap got %b want 0000", channelPending); else passCount++;
        step();
        checkCount++;
        if (channelPending !== 4'b0010) $display("FAIL periodic_second got %b want 0010", channelPending); else passCount++;
    endtask

    task automatic test_w1c_collision();
        doReset();
        busWrite(8'h00, 32'h0);
        busWrite(8'h14, 32'h0);
        busWrite(8'h10, 32'h3);
        step();
        checkCount++;
        if (channelPending[0] !== 1'b1) $display("FAIL collide_pre got %b want 1", channelPending[0]); else passCount++;
        busWrite(8'h04, 32'h1);
        checkCount++;
        if (channelPending[0] !== 1'b1) $display("FAIL collide_keep got %b want 1", channelPending[0]); else passCount++;
        busWrite(8'h10, 32'h0);
        busWrite(8'h04, 32'h1);
        checkCount++;
        if (channelPending[0] !== 1'b0) $display("FAIL collide_clear got %b want 0", channelPending[0]); else passCount++;
    endtask

    task automatic test_ctrl_priority();
        logic [31:0] rd;
        logic        v;
        doReset();
        busWrite(8'h00, 32'h0);
        busWrite(8'h34, 32'd5);
        busWrite(8'h30, 32'h1);
        step();
        busWrite(8'h30, 32'h3);
        busRead(8'h38, rd, v);
        checkCount++;
        if (rd !== 32'd4) $display("FAIL prio_count got %0d want 4", rd); else passCount++;
        busRead(8'h30, rd, v);
        checkCount++;
        if (rd !== 32'h3) $display("FAIL prio_ctrl got %h want 3", rd); else passCount++;
        busRead(8'hF0, rd, v);
        checkCount++;
        if (rd !== 32'h0 || v !== 1'b1) $display("FAIL unmapped_read got %h/%b want 0/1", rd, v); else passCount++;
        step();
        checkCount++;
        if (ioReadValidData !== 1'b0) $display("FAIL read_pulse got %b want 0", ioReadValidData); else passCount++;
        busWrite(8'h54, 32'hFFFF);
        busRead(8'h54, rd, v);
        checkCount++;
        if (rd !== 32'h0) $display("FAIL oob_channel got %h want 0", rd); else passCount++;
        busRead(8'h0C, rd, v);
        checkCount++;
        if (rd !== 32'h0) $display("FAIL hole_read got %h want 0", rd); else passCount++;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd;
        logic        v;
        doReset();
        busWrite(8'h00, 32'h0);
        busWrite(8'h08, 32'hF);
        busWrite(8'h14, 32'h0);
        busWrite(8'h10, 32'h3);
        busWrite(8'h34, 32'd9);
        busWrite(8'h30, 32'h1);
        busRead(8'h34, rd, v);
        repeat (2) step();
        busRead(8'h38, rd, v);
        checkCount++;
        if (rd !== 32'd6 || channelPending[0] !== 1'b1 || timerInterrupt !== 1'b1)
            $display("FAIL midflight_pre got %0d/%b/%b want 6/1/1", rd, channelPending[0], timerInterrupt); else passCount++;
        #2;
        resetActiveLow = 1'b0;
        #1;
        checkCount++;
        if (channelPending !== 4'b0 || timerInterrupt !== 1'b0 || systemResetRequest !== 1'b0
            || ioReadData !== 32'h0 || ioReadValidData !== 1'b0)
            $display("FAIL midflight_outputs got %b/%b/%b/%h/%b want all 0", channelPending, timerInterrupt,
                     systemResetRequest, ioReadData, ioReadValidData); else passCount++;
        resetActiveLow = 1'b1;
        step();
        busRead(8'h38, rd, v);
        checkCount++;
        if (rd !== 32'h0) $display("FAIL midflight_count got %0d want 0", rd); else passCount++;
        busRead(8'h30, rd, v);
        checkCount++;
        if (rd !== 32'h0) $display("FAIL midflight_ctrl got %h want 0", rd); else passCount++;
    endtask

    task automatic test_watchdog();
        doReset();
        busWrite(8'h00, 32'h0);
        busWrite(8'h14, 32'd2);
        busWrite(8'h10, 32'h3);
        repeat (5) step();
        checkCount++;
        if (systemResetRequest !== 1'b0) $display("FAIL watchdog_early got %b want 0", systemResetRequest); else passCount++;
        step();
        checkCount++;
        if (systemResetRequest !== WATCHDOG) $display("FAIL watchdog_fire got %b want %b", systemResetRequest, WATCHDOG); else passCount++;
        busWrite(8'h04, 32'h1);
        repeat (3) step();
        checkCount++;
        if (systemResetRequest !== WATCHDOG) $display("FAIL watchdog_sticky got %b want %b", systemResetRequest, WATCHDOG); else passCount++;
    endtask

    // One-shot expiry edge derived from tick arithmetic: counting edges from the PRESCALE write,
    // ticks land on multiples of (p+1); the first one after the CTRL write (edge 2) starts the
    // countdown, and the (r+1)-th effective tick expires the channel.
    task automatic test_random_oneshot();
        for (int it = 0; it < 8; it++) begin
            int unsigned p;
            int unsigned r;
            int unsigned ch;
            int unsigned firstTick;
            int unsigned expEdge;
            logic [3:0]  mask;
            logic [3:0]  wantPending;
            logic [7:0]  base;
            logic [31:0] rd;
            logic        v;
            p    = $urandom_range(3, 0);
            r    = $urandom_range(6, 0);
            ch   = $urandom_range(CH - 1, 0);
            mask = 4'($urandom_range(15, 0));
            base = 8'(16 + 16 * ch);
            wantPending = 4'(1 << ch);
            firstTick   = 2 / (p + 1) + 1;
            expEdge     = (firstTick + r) * (p + 1);
            doReset();
            busWrite(8'h08, 32'(mask));
            busWrite(8'h00, p);
            busWrite(base + 8'h4, r);
            busWrite(base, 32'h1);
            repeat (expEdge - 3) step();
            checkCount++;
            if (channelPending !== 4'b0)
                $display("FAIL rand_early it=%0d p=%0d r=%0d ch=%0d got %b want 0000", it, p, r, ch, channelPending);
            else passCount++;
            step();
            checkCount++;
            if (channelPending !== wantPending)
                $display("FAIL rand_expire it=%0d p=%0d r=%0d ch=%0d got %b want %b", it, p, r, ch, channelPending, wantPending);
            else passCount++;
            step();
            checkCount++;
            if (timerInterrupt !== mask[ch])
                $display("FAIL rand_irq it=%0d mask=%b ch=%0d got %b want %b", it, mask, ch, timerInterrupt, mask[ch]);
            else passCount++;
            busRead(base, rd, v);
            checkCount++;
            if (rd !== 32'h0) $display("FAIL rand_ctrl it=%0d got %h want 0", it, rd); else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_w1c_collision();
        test_ctrl_priority();
        test_reset_midflight();
        test_watchdog();
        test_random_oneshot();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter CHANNEL_COUNT, default 4, number of independent timer channels (legal 1..8).
REQ-002 SHALL have parameter COUNTER_WIDTH, default 32, width of each channel counter and reload register (legal 8..32).
REQ-003 SHALL have parameter PRESCALE_WIDTH, default 16, width of the shared prescaler.
REQ-004 SHALL have port clock  input  1  single block clock, rising-edge.
REQ-005 SHALL have port resetActiveLow  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port ioWriteValid  input  1  one-cycle MMIO write strobe.
REQ-007 SHALL have port ioWriteAddress  input  8  byte offset within the block.
REQ-008 SHALL have port ioWriteData  input  32  write data.
REQ-009 SHALL have port ioReadValid  input  1  one-cycle MMIO read strobe.
REQ-010 SHALL have port ioReadAddress  input  8  byte offset within the block.
REQ-011 SHALL have port ioReadData  output  32  registered read data.
REQ-012 SHALL have port ioReadValidData  output  1  pulses one cycle after ioReadValid.
REQ-013 SHALL have port channelPending  output  CHANNEL_COUNT  per-channel pending flags.
REQ-014 SHALL have port timerInterrupt  output  1  registered OR of pending AND irqEnable.
REQ-015 SHALL have port systemResetRequest  output  1  watchdog reset request (see Configuration).

Function
REQ-016 SHALL map 0x00 PRESCALE (RW), 0x04 STATUS (pending, W1C), 0x08 IRQ_MASK (RW); channel n at 0x10+0x10*n: +0 CTRL {bit0 enable, bit1 periodic}, +4 RELOAD (RW), +8 COUNT (RO).
REQ-017 SHALL generate a tick when prescaleCount equals PRESCALE, then zero prescaleCount; otherwise increment it; PRESCALE=0 ticks every cycle.
REQ-018 SHALL zero prescaleCount on any PRESCALE write.
REQ-019 SHALL load COUNT from RELOAD in the cycle CTRL.enable is written 0->1.
REQ-020 SHALL, per enabled channel on a tick: COUNT!=0 -> decrement; COUNT==0 -> set pending, then reload if periodic, else clear enable and hold COUNT at 0.
REQ-021 SHALL give a software write to CTRL or RELOAD priority over a same-cycle tick for that channel.
REQ-022 SHALL keep pending set when a W1C clear and a new expiry of the same channel coincide.
REQ-023 SHALL drive timerInterrupt exactly one cycle after the pending/mask condition changes.
REQ-024 SHALL return ioReadData one cycle after ioReadValid; unmapped or out-of-range channel offsets read 0 and writes to them are ignored.
REQ-025 SHALL write only the low COUNTER_WIDTH bits of RELOAD and zero-extend COUNT/RELOAD on read.
REQ-026 SHALL drive channelPending combinationally from the pending registers.

Reset
REQ-027 SHALL, while resetActiveLow=0, clear PRESCALE, prescaleCount, IRQ_MASK, all CTRL, RELOAD, COUNT, pending, ioReadData, ioReadValidData, timerInterrupt, systemResetRequest immediately.
REQ-028 SHALL abandon any in-flight countdown or read on reset mid-operation; no tick occurs in the first cycle after deassertion.

Configuration
REQ-029 SHALL, with TIMER_BANK_WATCHDOG_EN defined, assert systemResetRequest (sticky until reset) when channel 0 expires while its pending bit is already set.
REQ-030 SHALL, without TIMER_BANK_WATCHDOG_EN, tie systemResetRequest to 0 and treat channel 0 as an ordinary channel.

Verification
REQ-031 SHALL cover: PRESCALE=0, RELOAD0=3, CTRL0=0x1 -> pending[0]=1 after 4 ticks, timerInterrupt=1 one cycle later with IRQ_MASK=0x1, CTRL0.enable reads 0.
REQ-032 SHALL cover: PRESCALE=2, RELOAD1=1, CTRL1=0x3 -> pending[1] set every 6 cycles; W1C STATUS=0x2 clears it; COUNT1 reads 1 after each reload.
REQ-033 SHALL cover: W1C of pending[0] in the expiry cycle -> pending[0] stays 1.
REQ-034 SHALL cover: CTRL write coincident with tick -> write value wins, COUNT unchanged by tick; read of 0xF0 -> 0x0 with ioReadValidData pulse.
REQ-035 SHALL cover: resetActiveLow=0 mid-countdown (COUNT2=5) -> all outputs 0 at once, COUNT2 reads 0 after release.
REQ-036 SHALL cover, TIMER_BANK_WATCHDOG_EN defined: channel 0 periodic RELOAD=2, no W1C -> systemResetRequest=1 at second expiry; undefined -> stays 0.
